// File: rtl/alu_seq.sv
// alu_seq: valid/ready request sequencer driving an external 8-bit ALU.
// Define ALU_SEQ_MUL_EN to build the 8-pass low-half multiply (op 5); otherwise op 5 is reserved.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state;
  logic [2:0]       op;
  logic [WIDTH-1:0] a, b, res;
  logic             valid_op, last, lt, res_zero;
`ifdef ALU_SEQ_MUL_EN
  logic [2:0]       cnt;
  logic [WIDTH-1:0] acc;
  assign valid_op = op <= 3'd5;
  assign last     = op != 3'd5 || cnt == 3'd7;
`else
  assign valid_op = op <= 3'd4;
  assign last     = 1'b1;
`endif
  assign req_ready = state == IDLE && !rst;
  // SLT: on sign mismatch the SUB result may have overflowed, so A's sign decides
  assign lt       = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : alu_out[WIDTH-1];
  assign res      = !valid_op ? '0 : op == 3'd4 ? {{(WIDTH-1){1'b0}}, lt} : alu_out;
  assign res_zero = !valid_op ? 1'b1 : op == 3'd4 ? !lt : alu_zero;
  always_comb begin
    alu_sel = 4'b1111;
    alu_a   = '0;
    alu_b   = '0;
    if (state == EXEC && valid_op) begin
      alu_sel = op == 3'd0 ? 4'b0010 : op == 3'd1 ? 4'b0110 : op == 3'd2 ? 4'b0000 :
                op == 3'd3 ? 4'b0001 : op == 3'd4 ? 4'b0110 : 4'b0010;
      alu_a   = a;
      alu_b   = b;
`ifdef ALU_SEQ_MUL_EN
      if (op == 3'd5) begin
        alu_a = acc;
        alu_b = b[cnt] ? a << cnt : '0;
      end
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
      op        <= '0;
      a         <= '0;
      b         <= '0;
`ifdef ALU_SEQ_MUL_EN
      cnt       <= '0;
      acc       <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          state <= EXEC;
          op    <= req_op;
          a     <= req_a;
          b     <= req_b;
`ifdef ALU_SEQ_MUL_EN
          cnt   <= '0;
          acc   <= '0;
`endif
        end
        EXEC: begin
`ifdef ALU_SEQ_MUL_EN
          cnt <= cnt + 3'd1;
          acc <= alu_out;
`endif
          if (last) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= res;
            rsp_zero  <= res_zero;
            rsp_err   <= !valid_op;
          end
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Request-driven sequencer that sits in front of the 8-bit combinational ALU and acts as its initiator. It accepts operation requests over a valid/ready port and drives the ALU's `A`/`B`/`Sel` inputs. It captures the ALU's `Out`/`Zero` and returns results over a valid/ready response port. It also builds multi-pass operations (signed set-less-than, and optionally an 8×8 low-half multiply) from repeated ALU passes.

## Interface
- `WIDTH`, 8, datapath width; must equal the ALU width (8).

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer can accept a request.
- `req_op` in 3: operation code (0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 MUL, 6–7 reserved).
- `req_a` in 8: operand A.
- `req_b` in 8: operand B.
- `rsp_valid` out 1: result present.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_data` out 8: result.
- `rsp_zero` out 1: high when `rsp_data == 0`.
- `rsp_err` out 1: high when the op was reserved or not compiled in.
- `alu_a` out 8: drives ALU `A`.
- `alu_b` out 8: drives ALU `B`.
- `alu_sel` out 4: drives ALU `Sel`.
- `alu_out` in 8: from ALU `Out`.
- `alu_zero` in 1: from ALU `Zero`.

## Operation
- FSM states and transitions:
  - IDLE goes to EXEC on `req_valid & req_ready`.
  - EXEC goes to RESP when the last pass completes.
  - RESP goes to IDLE on `rsp_valid & rsp_ready`.
- `req_ready` = (state == IDLE) & !rst. The sequencer never accepts a request while in EXEC or RESP.
- On accept: latch `req_op`, `req_a`, `req_b`, clear the pass counter and clear the accumulator.
- ALU drive:
  - In IDLE and RESP: `alu_sel`=4'b1111 (ALU default, output 0), `alu_a`=`alu_b`=0.
  - In EXEC: driven combinationally from latched registers only.
- Op mapping and results:
  - ADD: `alu_sel`=0010. Result = `alu_out`, zero = `alu_zero`. 1 pass.
  - SUB: `alu_sel`=0110. Result = `alu_out`, zero = `alu_zero`. 1 pass.
  - AND: `alu_sel`=0000. Result = `alu_out`, zero = `alu_zero`. 1 pass.
  - OR: `alu_sel`=0001. Result = `alu_out`, zero = `alu_zero`. 1 pass.
  - SLT (signed): one SUB pass, d = `alu_out`. lt = (a[7] != b[7]) ? a[7] : d[7]. Result = {7'b0, lt}, zero = !lt.
  - MUL: 8 passes with `alu_sel`=0010.
    - Pass i (i = 0..7): `alu_a` = acc, `alu_b` = b[i] ? (a << i) : 0.
    - acc <= `alu_out` each pass.
    - Result = acc after pass 7, i.e. low 8 bits of a·b (overflow discarded). zero = (result == 0).
  - Reserved (6–7, or 5 without the macro): 1 EXEC cycle with the ALU left idle. Result 0, zero 1, `rsp_err` 1.
- `rsp_err` is 0 for every valid op.
- RESP holds `rsp_data`, `rsp_zero` and `rsp_err` stable until the handshake completes.

## Timing
- Reset values: state IDLE, `rsp_valid` 0, `rsp_data` 0x00, `rsp_zero` 0, `rsp_err` 0, `req_ready` 0 while `rst` is high, `alu_sel` 4'b1111, `alu_a`/`alu_b` 0.
- Let E0 be the accepting edge.
  - Single-pass ops: result registered at E1; `rsp_valid` is high from E1.
  - MUL: result registered at E8; `rsp_valid` is high from E8.
- Response handshake: an edge with `rsp_valid & rsp_ready` returns the FSM to IDLE, and `req_ready` is high the following cycle. Minimum issue interval is 3 cycles for single-pass ops and 10 for MUL.
- Backpressure: if `rsp_ready` stays low, the FSM remains in RESP indefinitely and outputs do not change.
- Reset mid-operation (EXEC or RESP): the op is abandoned with no response. All outputs return to reset values at the reset edge.
- `req_*` inputs are ignored outside IDLE, so input changes during EXEC do not affect the result.

## Configuration
- `ALU_SEQ_MUL_EN` defined: op 5 executes the 8-pass multiply described above.
- `ALU_SEQ_MUL_EN` undefined: the multiplier datapath (accumulator, shifted multiplicand, pass counter above 1) is not compiled. Op 5 behaves as reserved: 1 EXEC cycle, result 0x00, `rsp_zero` 1, `rsp_err` 1.

## Test plan
- ADD 0x7F + 0x01: `alu_sel`=0010 in EXEC; `rsp_data`=0x80, `rsp_zero`=0, `rsp_err`=0; `rsp_valid` rises exactly 1 cycle after accept.
- SUB 0x05 − 0x05 gives 0x00 with `rsp_zero`=1. SLT a=0x80, b=0x01 gives 0x01 with `rsp_zero`=0. SLT a=0x01, b=0x80 gives 0x00 with `rsp_zero`=1.
- MUL (macro on) 0x0D·0x0B: `rsp_data`=0x8F, valid 8 cycles after accept. MUL 0x10·0x10 gives 0x00 with `rsp_zero`=1.
- Op 7 (and op 5 with the macro off): `rsp_data`=0x00, `rsp_zero`=1, `rsp_err`=1.
- Hold `rsp_ready` low for 5 cycles after an AND 0xF0 & 0x3C: `rsp_data` stays 0x30, `req_ready` stays 0, and a concurrent `req_valid` is not accepted.
- Assert `rst` at pass 4 of a MUL: no response is produced; `req_ready` is 1 the first cycle after `rst` deasserts; a following ADD completes correctly.
